// File: rtl/seg7_scan_driver_pkg.sv
// Package: seg7_scan_driver_pkg
// Shared definitions for the 7-segment scan driver:
//   - display-dark constants for segments and anodes
//   - scan FSM state encoding
//   - leading-zero blanking helper
package seg7_scan_driver_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;  // {dp,g..a} all off (active low)
  localparam logic [3:0] AN_OFF  = 4'hF;   // no digit enabled (active low)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  // Bit k set when digit k must be dark because it and every digit above it
  // is zero. Digit 0 is never blanked, so a value of 0 still shows "0".
  function automatic logic [3:0] lz_blank_mask(input logic [15:0] v);
    logic [3:0] m;
    m[3] = (v[15:12] == 4'h0);
    m[2] = m[3] & (v[11:8] == 4'h0);
    m[1] = m[2] & (v[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Module: hex_to_seg7
// Combinational hex nibble to 7-segment decoder, active-low outputs.
// Ports:
//   i_hex  in  4  nibble to display
//   o_seg  out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg7 (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Module: seg7_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with
// an all-off blanking gap between digits and frame-aligned input shadowing.
// Ports:
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   en          in   1   1 = scan running, 0 = display dark
//   value       in   16  four hex digits, [3:0] = rightmost digit
//   dp_mask     in   4   decimal point per digit, 1 = lit
//   blank_lz    in   1   1 = blank leading zero digits
//   scan_sel    out  2   digit index currently shown (held through its gap)
//   AN          out  4   anode enables, active low
//   SEGMENT     out  8   {dp,g,f,e,d,c,b,a}, active low
//   frame_done  out  1   one-cycle pulse when digit 3's slot completes
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 64,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [1:0]  scan_sel,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit               HAS_BLANK  = (BLANK_CYC > 0);

  scan_state_t      r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]       r_sel, w_sel_next;
  logic [3:0]       r_an, w_an_next;
  logic [7:0]       r_seg, w_seg_next;
  logic             r_frame_done, w_frame_done_next;
  logic [15:0]      r_shadow_value;
  logic [3:0]       r_shadow_dp;
  logic             r_shadow_lz;

  logic             w_go_show;
  logic [1:0]       w_tgt_sel;
  logic             w_wrap;
  logic [15:0]      w_src_value;
  logic [3:0]       w_src_dp;
  logic             w_src_lz;
  logic [3:0]       w_lz_mask;
  logic [3:0]       w_nibble;
  logic [6:0]       w_hex_seg;
  logic [7:0]       w_show_seg;

  // The digit the next SHOW entry will display. Entering from IDLE or
  // wrapping past digit 3 starts a new frame, which is the only moment the
  // live inputs are allowed through; otherwise the frame's shadow copy is used
  // so a mid-frame update cannot tear the displayed number.
  assign w_tgt_sel   = (r_state == ST_IDLE) ? 2'd0 : r_sel + 2'd1;
  assign w_wrap      = (r_state == ST_IDLE) || (r_sel == 2'd3);
  assign w_src_value = w_wrap ? value    : r_shadow_value;
  assign w_src_dp    = w_wrap ? dp_mask  : r_shadow_dp;
  assign w_src_lz    = w_wrap ? blank_lz : r_shadow_lz;
  assign w_lz_mask   = lz_blank_mask(w_src_value) & {4{w_src_lz}};
  assign w_nibble    = w_src_value[{w_tgt_sel, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .i_hex (w_nibble),
    .o_seg (w_hex_seg)
  );

  // A blanked leading zero keeps its anode enabled but lights no segments;
  // its decimal point is still honoured.
  assign w_show_seg = {~w_src_dp[w_tgt_sel],
                       w_lz_mask[w_tgt_sel] ? 7'h7F : w_hex_seg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_sel          <= 2'd0;
      r_an           <= AN_OFF;
      r_seg          <= SEG_OFF;
      r_frame_done   <= 1'b0;
      r_shadow_value <= '0;
      r_shadow_dp    <= '0;
      r_shadow_lz    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_sel        <= w_sel_next;
      r_an         <= w_an_next;
      r_seg        <= w_seg_next;
      r_frame_done <= w_frame_done_next;
      if (w_go_show && w_wrap) begin
        r_shadow_value <= value;
        r_shadow_dp    <= dp_mask;
        r_shadow_lz    <= blank_lz;
      end
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt + CNT_W'(1);
    w_sel_next        = r_sel;
    w_an_next         = r_an;
    w_seg_next        = r_seg;
    w_frame_done_next = 1'b0;
    w_go_show         = 1'b0;

    if (!en) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_sel_next   = 2'd0;
      w_an_next    = AN_OFF;
      w_seg_next   = SEG_OFF;
    end else begin
      case (r_state)
        ST_IDLE: w_go_show = 1'b1;
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            if (HAS_BLANK) begin
              w_state_next = ST_BLANK;
              w_cnt_next   = '0;
              w_an_next    = AN_OFF;
              w_seg_next   = SEG_OFF;
            end else begin
              w_go_show = 1'b1;
            end
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) w_go_show = 1'b1;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_sel_next   = 2'd0;
          w_an_next    = AN_OFF;
          w_seg_next   = SEG_OFF;
        end
      endcase

      // Anodes and segments load together so they never disagree for a cycle.
      if (w_go_show) begin
        w_state_next      = ST_SHOW;
        w_cnt_next        = '0;
        w_sel_next        = w_tgt_sel;
        w_an_next         = ~(4'b0001 << w_tgt_sel);
        w_seg_next        = w_show_seg;
        w_frame_done_next = (r_state != ST_IDLE) && (r_sel == 2'd3);
      end
    end
  end

  assign scan_sel   = r_sel;
  assign AN         = r_an;
  assign SEGMENT    = r_seg;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: two instances (with and without a blanking
// gap) share stimulus; a timeline model predicts every cycle's outputs and a
// set of literal expectations pins the model.
module tb_seg7_scan_driver;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic        blank_lz = 1'b0;

  logic [1:0] sel_a, sel_b;
  logic [3:0] an_a, an_b;
  logic [7:0] seg_a, seg_b;
  logic       fd_a, fd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(S), .BLANK_CYC(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .scan_sel(sel_a), .AN(an_a), .SEGMENT(seg_a),
    .frame_done(fd_a)
  );

  seg7_scan_driver #(.SCAN_DIV(S), .BLANK_CYC(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .scan_sel(sel_b), .AN(an_b), .SEGMENT(seg_b),
    .frame_done(fd_b)
  );

  // ---------------- timeline model ----------------
  // Each instance is modelled as "cycles since the scan started" (m_t); the
  // digit, phase and frame follow from plain division by the slot length.
  int          m_blank [2] = '{2, 0};
  bit          m_act   [2];
  int          m_t     [2];
  logic [15:0] m_val   [2];
  logic [3:0]  m_dp    [2];
  bit          m_lz    [2];
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic capture(input int k);
    m_val[k] = value;
    m_dp[k]  = dp_mask;
    m_lz[k]  = blank_lz;
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || !en) begin
        m_act[k] = 1'b0;
      end else if (!m_act[k]) begin
        m_act[k] = 1'b1;
        m_t[k]   = 0;
        capture(k);
      end else begin
        m_t[k] = m_t[k] + 1;
        if (m_t[k] % (4 * (S + m_blank[k])) == 0) capture(k);
      end
    end
  end

  function automatic logic [14:0] model_out(input int k);
    int p, d, ph;
    logic [15:0] hi;
    logic [1:0] sel;
    logic [3:0] an;
    logic [7:0] seg;
    logic fd;
    sel = 2'd0; an = 4'hF; seg = 8'hFF; fd = 1'b0;
    if (m_act[k]) begin
      p   = S + m_blank[k];
      d   = (m_t[k] / p) % 4;
      ph  = m_t[k] % p;
      sel = d[1:0];
      fd  = (m_t[k] > 0) && (m_t[k] % (4 * p) == 0);
      if (ph < S) begin
        an     = ~(4'b0001 << d);
        hi     = m_val[k] >> (4 * d);
        seg[7] = ~m_dp[k][d];
        if (m_lz[k] && d > 0 && hi == 16'h0) seg[6:0] = 7'h7F;
        else                                 seg[6:0] = hex_tab[hi[3:0]];
      end
    end
    return {sel, an, seg, fd};
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [14:0] exp_a, exp_b;
    exp_a = model_out(0);
    exp_b = model_out(1);
    checks++;
    if ({sel_a, an_a, seg_a, fd_a} !== exp_a) begin
      errors++;
      $display("FAIL cycle_dut_a t=%0t: got sel/an/seg/fd=%h required %h",
               $time, {sel_a, an_a, seg_a, fd_a}, exp_a);
    end
    checks++;
    if ({sel_b, an_b, seg_b, fd_b} !== exp_b) begin
      errors++;
      $display("FAIL cycle_dut_b t=%0t: got sel/an/seg/fd=%h required %h",
               $time, {sel_b, an_b, seg_b, fd_b}, exp_b);
    end
  end

  // ---------------- literal expectations ----------------
  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("check %s: %h", name, act);
    end
  endtask

  // Advance to just after the n-th following falling edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held with en=1
    rst_n = 1'b0; en = 1'b1; value = 16'h1234; dp_mask = 4'h0; blank_lz = 1'b0;
    wait_cyc(3);
    lit("rst_an",   {4'h0, an_a}, 8'h0F);
    lit("rst_seg",  seg_a, 8'hFF);
    lit("rst_sel",  {6'h0, sel_a}, 8'h00);
    lit("rst_fd",   {7'h0, fd_a}, 8'h00);
    rst_n = 1'b1;

    // 2: normal scan of 1234, then 4: mid-frame change to ABCD
    wait_cyc(1);                                 // t=0
    lit("d0_an",  {4'h0, an_a}, 8'h0E);
    lit("d0_seg", seg_a, 8'h99);
    wait_cyc(4);                                 // t=4
    lit("gap0_an",  {4'h0, an_a}, 8'h0F);
    lit("gap0_seg", seg_a, 8'hFF);
    lit("b_d1_an",  {4'h0, an_b}, 8'h0D);
    lit("b_d1_seg", seg_b, 8'hB0);
    wait_cyc(2);                                 // t=6
    lit("d1_an",  {4'h0, an_a}, 8'h0D);
    lit("d1_seg", seg_a, 8'hB0);
    value = 16'hABCD;
    wait_cyc(6);                                 // t=12
    lit("d2_an",  {4'h0, an_a}, 8'h0B);
    lit("d2_seg_old", seg_a, 8'hA4);
    wait_cyc(6);                                 // t=18
    lit("d3_an",  {4'h0, an_a}, 8'h07);
    lit("d3_seg_old", seg_a, 8'hF9);
    wait_cyc(6);                                 // t=24
    lit("fd_pulse",   {7'h0, fd_a}, 8'h01);
    lit("new_d0_seg", seg_a, 8'hA1);
    wait_cyc(1);                                 // t=25
    lit("fd_one_cycle", {7'h0, fd_a}, 8'h00);

    // 5: drop enable during digit 2
    wait_cyc(11);                                // t=36
    lit("pre_drop_an", {4'h0, an_a}, 8'h0B);
    en = 1'b0;
    wait_cyc(1);
    lit("drop_an",  {4'h0, an_a}, 8'h0F);
    lit("drop_sel", {6'h0, sel_a}, 8'h00);
    wait_cyc(2);
    en = 1'b1;
    wait_cyc(1);
    lit("restart_an", {4'h0, an_a}, 8'h0E);
    lit("restart_fd", {7'h0, fd_a}, 8'h00);

    // 3: leading-zero blanking
    en = 1'b0; blank_lz = 1'b1; value = 16'h0070;
    wait_cyc(1);
    en = 1'b1;
    wait_cyc(1);
    lit("lz_d0", seg_a, 8'hC0);
    wait_cyc(6);
    lit("lz_d1", seg_a, 8'hF8);
    wait_cyc(6);
    lit("lz_d2_an",  {4'h0, an_a}, 8'h0B);
    lit("lz_d2_seg", seg_a, 8'hFF);
    wait_cyc(6);
    lit("lz_d3_seg", seg_a, 8'hFF);
    en = 1'b0; value = 16'h0000;
    wait_cyc(1);
    en = 1'b1;
    wait_cyc(1);
    lit("zero_d0", seg_a, 8'hC0);
    wait_cyc(6);
    lit("zero_d1_an",  {4'h0, an_a}, 8'h0D);
    lit("zero_d1_seg", seg_a, 8'hFF);

    // 6: no-gap instance with decimal points on digits 0 and 2
    en = 1'b0; blank_lz = 1'b0; value = 16'h1234; dp_mask = 4'b0101;
    wait_cyc(1);
    en = 1'b1;
    wait_cyc(1);
    lit("ng_d0_an",  {4'h0, an_b}, 8'h0E);
    lit("ng_d0_seg", seg_b, 8'h19);
    wait_cyc(3);
    lit("ng_d0_last_an", {4'h0, an_b}, 8'h0E);
    wait_cyc(1);
    lit("ng_d1_an",  {4'h0, an_b}, 8'h0D);
    lit("ng_d1_seg", seg_b, 8'hB0);
    wait_cyc(4);
    lit("ng_d2_an",  {4'h0, an_b}, 8'h0B);
    lit("ng_d2_seg", seg_b, 8'h24);
    wait_cyc(4);
    lit("ng_d3_an",  {4'h0, an_b}, 8'h07);
    lit("ng_d3_seg", seg_b, 8'hF9);

    // Asynchronous reset mid-scan darkens the display before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_an_a",  {4'h0, an_a}, 8'h0F);
    lit("async_seg_a", seg_a, 8'hFF);
    lit("async_an_b",  {4'h0, an_b}, 8'h0F);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    lit("post_rst_an", {4'h0, an_a}, 8'h0E);
    wait_cyc(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
